obstacle_lane: RTL and testbench
================================

// Module: obstacle_lane
// PURPOSE
// - Consumer of the horizontal scroll generator's one-cycle move pulse. Owns one road lane of up to NUM_CARS cars.
// - On each pulse: advances every car, despawns cars that leave the screen, spawns new cars at the left edge from an LFSR.
// - Feeds a registered pixel-on flag to the VGA mux and a sticky player-collision flag to game control.
// PARAMETERS
// - SCREEN_WIDTH  640     visible width in pixels; despawn bound
// - NUM_CARS      4       car slots in the lane
// - STEP          2       pixels moved per move_tick
// - CAR_W         32      car width in pixels
// - MIN_GAP       64      min pixels between the leftmost active car and a new spawn
// - LANE_Y        240     lane top row
// - LANE_H        32      lane height in rows
// - PLAYER_W      16      player square size in pixels
// - SPAWN_THRESH  3       spawn allowed when lfsr[2:0] < SPAWN_THRESH (range 0..8)
// - LFSR_SEED     16'hACE1  reset value of the LFSR; must be nonzero
// PORTS
// - clk          in   1   system clock (25 MHz)
// - reset        in   1   synchronous, active-high
// - move_tick    in   1   one-cycle pulse from the scroll generator
// - score        in   7   current score
// - pix_x        in   10  VGA beam column
// - pix_y        in   10  VGA beam row
// - player_x     in   10  player left edge
// - player_y     in   10  player top edge
// - obstacle_px  out  1   beam is on a car (1-cycle latency)
// - collide      out  1   sticky player/car overlap
// - car_count    out  3   number of active slots
// BEHAVIOUR
// - State per slot i: x[i] (10b, left edge) and act[i]. Also a 16b Galois LFSR, taps x^16+x^14+x^13+x^11.
// - Reset has priority over all other inputs, including a move_tick in the same cycle. On reset:
//   - act=0, x=0, lfsr=LFSR_SEED
//   - obstacle_px=0, collide=0, car_count=0
// - move_tick=0: slot state and LFSR hold.
// - move_tick=1, all in the same cycle:
//   - Step is computed 11b wide: nx = x + step, with step = STEP.
//   - If act and nx >= SCREEN_WIDTH: act <= 0 (despawn). Otherwise, if act: x <= nx[9:0].
//   - Spawn conditions: lfsr[2:0] < SPAWN_THRESH (pre-advance value), AND a free slot exists, AND no car that remains active has nx < CAR_W+MIN_GAP.
//   - Spawn action: the lowest-index free slot gets x <= 0, act <= 1.
//   - A slot despawning in this cycle counts as not free until the next tick.
//   - lfsr advances one step.
// - obstacle_px (registered): pix_y in [LANE_Y, LANE_Y+LANE_H) AND, for some active slot, x <= pix_x < x+CAR_W. Compares are 11b; no wrap at the right edge.
// - collide (registered, sticky): set when any active car's rectangle overlaps the player square (strict <, 11b compares). It clears only on reset.
// - car_count (registered): popcount of act; it reflects a tick one cycle after the tick.
// - Back-to-back move_tick pulses on consecutive cycles are legal; each pulse is processed.
// CONFIGURATION
// - SCORE_SPEEDUP_EN defined: step = STEP + score[6:5] (range STEP..STEP+3). The despawn, gap and spawn rules are unchanged.
// - SCORE_SPEEDUP_EN undefined: step = STEP; the score input is ignored.
// TESTING
// - Reset: assert reset with move_tick=1 -> next cycle obstacle_px=0, collide=0, car_count=0, lfsr=16'hACE1.
// - Spawn and draw: pulse move_tick until car_count=1. Then:
//   - pix=(0,240) -> obstacle_px=1 one cycle later
//   - pix=(32,240) -> 0
//   - pix=(0,272) -> 0
//   - after 1 more tick, pix=(33,240) -> 1
// - Gap: with one car active, no second spawn while its x < 96, whatever the LFSR value. A second spawn is possible from the tick where x reaches >= 96.
// - Despawn: drive a car to x=638, then pulse move_tick -> act cleared and car_count decrements; no pixel is drawn at columns 638..639 afterwards.
// - Collision: player at (10,250), car at x=0 -> collide=1 next cycle. collide stays 1 after the car passes; reset clears it.
// - SCORE_SPEEDUP_EN with score=96 -> car x advances by 5 per tick. Without the macro, score=96 -> advances by 2.

Source files
------------

// File: rtl/obstacle_lane.sv
// One road lane of up to NUM_CARS cars that scroll right on each move_tick and spawn from an LFSR.
// Optional macro SCORE_SPEEDUP_EN: the per-tick step grows with score[6:5].
module obstacle_lane #(
    parameter int          SCREEN_WIDTH = 640,
    parameter int          NUM_CARS     = 4,
    parameter int          STEP         = 2,
    parameter int          CAR_W        = 32,
    parameter int          MIN_GAP      = 64,
    parameter int          LANE_Y       = 240,
    parameter int          LANE_H       = 32,
    parameter int          PLAYER_W     = 16,
    parameter int          SPAWN_THRESH = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic [6:0] score,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       obstacle_px,
    output logic       collide,
    output logic [2:0] car_count
);

    logic [9:0]          x [NUM_CARS];
    logic [NUM_CARS-1:0] act;
    logic [15:0]         lfsr;

    logic [10:0]         step;
    logic [10:0]         nx [NUM_CARS];
    logic [NUM_CARS-1:0] stays;
    logic [NUM_CARS-1:0] spawn_sel;
    logic [NUM_CARS-1:0] hit;
    logic [NUM_CARS-1:0] overlap;
    logic                near;
    logic                found;
    logic                spawn_ok;
    logic                in_lane;
    logic                player_rows;
    logic [15:0]         lfsr_nxt;

`ifdef SCORE_SPEEDUP_EN
    assign step = 11'(STEP) + {9'd0, score[6:5]};
`else
    logic unused_score;
    assign unused_score = ^score;
    assign step = 11'(STEP);
`endif

    // Galois form, taps x^16+x^14+x^13+x^11
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign in_lane     = ({1'b0, pix_y} >= 11'(LANE_Y)) && ({1'b0, pix_y} < 11'(LANE_Y + LANE_H));
    assign player_rows = (11'(LANE_Y) < {1'b0, player_y} + 11'(PLAYER_W)) &&
                         ({1'b0, player_y} < 11'(LANE_Y + LANE_H));

    always_comb begin
        near      = 1'b0;
        found     = 1'b0;
        spawn_sel = '0;
        stays     = '0;
        hit       = '0;
        overlap   = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            nx[i]    = {1'b0, x[i]} + step;
            stays[i] = act[i] && (nx[i] < 11'(SCREEN_WIDTH));
            if (stays[i] && (nx[i] < 11'(CAR_W + MIN_GAP)))
                near = 1'b1;
            // A slot despawning this tick still reads as occupied here
            if (!act[i] && !found) begin
                found        = 1'b1;
                spawn_sel[i] = 1'b1;
            end
            hit[i] = act[i] && ({1'b0, x[i]} <= {1'b0, pix_x}) &&
                     ({1'b0, pix_x} < {1'b0, x[i]} + 11'(CAR_W));
            overlap[i] = act[i] && player_rows &&
                         ({1'b0, x[i]} < {1'b0, player_x} + 11'(PLAYER_W)) &&
                         ({1'b0, player_x} < {1'b0, x[i]} + 11'(CAR_W));
        end
        spawn_ok = ({1'b0, lfsr[2:0]} < 4'(SPAWN_THRESH)) && found && !near;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CARS; i++)
                x[i] <= '0;
            act         <= '0;
            lfsr        <= LFSR_SEED;
            obstacle_px <= 1'b0;
            collide     <= 1'b0;
            car_count   <= '0;
        end else begin
            if (move_tick) begin
                for (int i = 0; i < NUM_CARS; i++) begin
                    if (spawn_ok && spawn_sel[i]) begin
                        x[i]   <= '0;
                        act[i] <= 1'b1;
                    end else begin
                        act[i] <= stays[i];
                        if (stays[i])
                            x[i] <= nx[i][9:0];
                    end
                end
                lfsr <= lfsr_nxt;
            end
            obstacle_px <= in_lane && (|hit);
            collide     <= collide | (|overlap);
            car_count   <= 3'($countones(act));
        end
    end

endmodule

// File: tb/tb_obstacle_lane.sv
// Randomized bench for obstacle_lane: a lane-level reference model feeds an expected queue checked by a monitor.
module tb_obstacle_lane;

    localparam int NC = 4;

    logic       clk;
    logic       reset;
    logic       move_tick;
    logic [6:0] score;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       obstacle_px;
    logic       collide;
    logic [2:0] car_count;

    obstacle_lane dut (
        .clk(clk), .reset(reset), .move_tick(move_tick), .score(score),
        .pix_x(pix_x), .pix_y(pix_y), .player_x(player_x), .player_y(player_y),
        .obstacle_px(obstacle_px), .collide(collide), .car_count(car_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {obstacle_px, collide, car_count}
    logic [4:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // reference model of the lane
    int m_x[NC];
    bit m_act[NC];
    int m_lfsr;
    bit m_col;

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_x[i]   = 0;
            m_act[i] = 0;
        end
        m_lfsr = 16'hACE1;
        m_col  = 0;
    endtask

    function automatic int model_step(input int sc);
`ifdef SCORE_SPEEDUP_EN
        return 2 + ((sc >> 5) & 3);
`else
        return 2;
`endif
    endfunction

    task automatic model_tick(input int sc);
        bit was[NC];
        bit blocked;
        int slot;
        blocked = 0;
        slot    = -1;
        for (int i = 0; i < NC; i++) was[i] = m_act[i];
        for (int i = 0; i < NC; i++) begin
            if (m_act[i]) begin
                if (m_x[i] + model_step(sc) >= 640) m_act[i] = 0;
                else m_x[i] = m_x[i] + model_step(sc);
            end
            if (m_act[i] && m_x[i] < 96) blocked = 1;
        end
        for (int i = NC - 1; i >= 0; i--)
            if (!was[i]) slot = i;
        if ((m_lfsr % 8) < 3 && slot >= 0 && !blocked) begin
            m_x[slot]   = 0;
            m_act[slot] = 1;
        end
        if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 16'hB400;
        else m_lfsr = m_lfsr / 2;
    endtask

    function automatic logic [4:0] model_expect(input int px, input int py, input int plx, input int ply);
        bit obs;
        bit hitp;
        int cnt;
        obs  = 0;
        hitp = 0;
        cnt  = 0;
        for (int i = 0; i < NC; i++) begin
            if (m_act[i]) begin
                cnt++;
                if (py >= 240 && py < 272 && px >= m_x[i] && px < m_x[i] + 32) obs = 1;
                if (plx < m_x[i] + 32 && m_x[i] < plx + 16 && ply < 272 && 240 < ply + 16) hitp = 1;
            end
        end
        return {obs, m_col | hitp, 3'(cnt)};
    endfunction

    // driver
    task automatic drive_cycle(input bit rst, input bit tick);
        int offs[7];
        int rows[4];
        int px, py, plx, ply, sc, k;
        logic [4:0] e;
        offs = '{-1, 0, 1, 30, 31, 32, 33};
        rows = '{239, 240, 271, 272};
        @(negedge clk);
        sc = $urandom_range(0, 3) == 0 ? 96 : $urandom_range(0, 127);
        k  = $urandom_range(0, NC - 1);
        if ($urandom_range(0, 3) != 0) begin
            px = (m_x[k] + offs[$urandom_range(0, 6)]) & 1023;
            py = $urandom_range(0, 1) ? rows[$urandom_range(0, 3)] : $urandom_range(240, 271);
        end else begin
            px = $urandom_range(0, 1023);
            py = $urandom_range(0, 1023);
        end
        if ($urandom_range(0, 59) == 0) begin
            plx = (m_x[k] + $urandom_range(0, 60) - 20) & 1023;
            ply = $urandom_range(220, 280);
        end else begin
            plx = $urandom_range(0, 1023);
            ply = $urandom_range(0, 200);
        end
        reset     = rst;
        move_tick = tick;
        score     = 7'(sc);
        pix_x     = 10'(px);
        pix_y     = 10'(py);
        player_x  = 10'(plx);
        player_y  = 10'(ply);
        if (rst) begin
            exp_q.push_back(5'd0);
            model_reset();
        end else begin
            e = model_expect(px, py, plx, ply);
            exp_q.push_back(e);
            m_col = e[3];
            if (tick) model_tick(sc);
        end
    endtask

    // monitor
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests += 3;
                if (obstacle_px !== e[4]) begin
                    n_fail++;
                    $display("FAIL obstacle_px t=%0t got=%b exp=%b", $time, obstacle_px, e[4]);
                end
                if (collide !== e[3]) begin
                    n_fail++;
                    $display("FAIL collide t=%0t got=%b exp=%b", $time, collide, e[3]);
                end
                if (car_count !== e[2:0]) begin
                    n_fail++;
                    $display("FAIL car_count t=%0t got=%0d exp=%0d", $time, car_count, e[2:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        reset = 1'b1; move_tick = 1'b1; score = '0;
        pix_x = '0; pix_y = '0; player_x = '0; player_y = '0;
        model_reset();
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b1);
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 1499) == 0)
                drive_cycle(1'b1, 1'($urandom_range(0, 1)));
            else if (c % 2000 < 100)
                drive_cycle(1'b0, 1'b1);
            else
                drive_cycle(1'b0, $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 3; c++) drive_cycle(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d need=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
